spike_source_dispatcher: RTL and testbench
==========================================

// Module: spike_source_dispatcher
// PURPOSE
//  Transmit side of the spike interface that feeds the neuron MAC unit.
//  Collects addresses of neurons that fired in the current time step and buffers them in a FIFO.
//  Presents them one per transfer as source_address to the MAC, using a valid/ready handshake.
//  After the last spike of a step has drained, pulses step_clear so the MAC resets its accumulator for the next step.
// PARAMETERS
//  ADDR_W   12  neuron/source address width (matches MAC source_address)
//  DEPTH    8   FIFO entries, power of two, >= 2
//  CNT_W    8   width of per-step spike counter (saturating)
// PORTS
//  CLK            in   1       clock, rising-edge
//  RESET          in   1       asynchronous, active-high reset
//  fire_valid     in   1       producer offers a fired-neuron address
//  fire_address   in   ADDR_W  address of neuron that fired
//  fire_ready     out  1       dispatcher accepts fire_address this cycle
//  timestep_end   in   1       one-cycle pulse: no more spikes for this step
//  source_address out  ADDR_W  spike address toward MAC (FIFO head)
//  spike_valid    out  1       source_address is valid
//  spike_ready    in   1       MAC accepts spike this cycle
//  step_clear     out  1       one-cycle pulse: step fully drained, clear MAC
//  spike_count    out  CNT_W   spikes sent in current step, saturates at 2^CNT_W-1
//  overflow       out  1       sticky: fire_valid seen while full and not end-pending
// BEHAVIOUR
//  Reset (async):
//   - FIFO empty, state IDLE, source_address=0, spike_valid=0, step_clear=0.
//   - spike_count=0, overflow=0, end_pending=0.
//   - fire_ready=1 once RESET deasserts.
//  Handshakes:
//   - Input accept = fire_valid & fire_ready; output transfer = spike_valid & spike_ready.
//   - fire_ready = !full & !end_pending & (state!=CLEAR); combinational from registered state.
//   - spike_valid = !empty & (state!=CLEAR); source_address = FIFO head (show-ahead).
//   - source_address is held stable while spike_valid & !spike_ready.
//  FIFO behaviour:
//   - full/empty come from registered pointers with one extra wrap bit; pointers wrap modulo DEPTH.
//   - Simultaneous push and pop allowed when neither full nor empty; occupancy stays unchanged.
//   - When full, fire_ready=0 even if a pop occurs that cycle, so no push happens.
//   - Latency: an address accepted at edge N is visible on source_address after edge N when the FIFO was empty.
//   - Otherwise it is presented in FIFO order.
//  Overflow:
//   - Set when fire_valid & full & !end_pending; the producer must hold its data, and nothing is lost in the RTL.
//   - Cleared only by RESET.
//  Step end:
//   - timestep_end sets end_pending.
//   - A timestep_end arriving while end_pending or in CLEAR is ignored.
//  FSM:
//   - IDLE  : FIFO empty, no end pending. Push -> SEND. timestep_end with empty FIFO -> CLEAR.
//   - SEND  : draining. empty & end_pending after a pop (or already empty) -> CLEAR.
//             Empty & !end_pending -> IDLE.
//   - CLEAR : exactly one cycle. step_clear=1, spike_count<=0, end_pending<=0; next state IDLE.
//  Simultaneous events:
//   - timestep_end together with the final pop still yields CLEAR on the following cycle.
//   - timestep_end together with a push: the push is accepted (it belongs to the current step), then end_pending is set.
//   - A step with zero spikes still produces one step_clear.
//  spike_count:
//   - +1 per output transfer, saturating at its maximum.
//   - Holds its final value until the CLEAR cycle, where it is zeroed.
//  RESET mid-operation:
//   - All buffered spikes are discarded and no step_clear is emitted.
//   - Outputs return to their reset values immediately.
// TESTING
//  1 Push 3,4,5 back-to-back, spike_ready=1 -> source_address 3,4,5 on consecutive cycles.
//    Then timestep_end -> one step_clear; spike_count reads 3 before the clear and 0 after.
//  2 Push 8 entries (0x001..0x008), spike_ready=0 -> fire_ready=0 once full.
//    A 9th fire_valid sets overflow=1; release ready -> order 0x001..0x008 preserved.
//  3 spike_ready toggles 1/0 while draining 0x007,0x006 -> each address is held stable until accepted.
//    No duplicate or skipped address.
//  4 timestep_end on an empty FIFO -> step_clear high exactly one cycle later, spike_count=0.
//    A second timestep_end during CLEAR is ignored (one pulse only).
//  5 timestep_end in the same cycle as the last pop, then new fire_valid 0x00A offered ->
//    fire_ready=0 until after step_clear; 0x00A is then sent in the next step.
//  6 Assert RESET with 4 spikes buffered -> spike_valid=0, FIFO empty, overflow=0, no step_clear.

Source files
------------

// File: rtl/spike_source_dispatcher_if.sv
// Spike handshake bundle between the fired-neuron producer, the dispatcher and the MAC.
// The slave modport is the dispatcher's view; the master modport is the surrounding logic.
interface spike_source_dispatcher_if #(
    parameter int ADDR_W = 12
) ();
    logic              fire_valid;
    logic [ADDR_W-1:0] fire_address;
    logic              fire_ready;
    logic [ADDR_W-1:0] source_address;
    logic              spike_valid;
    logic              spike_ready;

    modport slave (
        input  fire_valid,
        input  fire_address,
        input  spike_ready,
        output fire_ready,
        output source_address,
        output spike_valid
    );

    modport master (
        output fire_valid,
        output fire_address,
        output spike_ready,
        input  fire_ready,
        input  source_address,
        input  spike_valid
    );
endinterface

// File: rtl/spike_source_dispatcher.sv
// Buffers fired-neuron addresses in a show-ahead FIFO, streams them to the MAC,
// and pulses step_clear once a time step has fully drained.
module spike_source_dispatcher #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    spike_source_dispatcher_if.slave    bus,
    input  logic                        timestep_end_i,
    output logic                        step_clear_o,
    output logic [CNT_W-1:0]            spike_count_o,
    output logic                        overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CLEAR = 2'd2
    } dispatchState_e;

    dispatchState_e      state_q;
    logic [ADDR_W-1:0]   mem_q [DEPTH];
    logic [PTR_W:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W:0]      rdPtr_q, rdPtr_d;
    logic                endPending_q, endPending_d;
    logic                stepClear_q;
    logic [CNT_W-1:0]    spikeCount_q;
    logic                overflow_q;

    logic full, empty, fireReady, spikeValid, push, pop, tsAccept, drainedNext;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign full  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign empty = (wrPtr_q == rdPtr_q);

    assign fireReady  = !full && !endPending_q && (state_q != CLEAR);
    assign spikeValid = !empty && (state_q != CLEAR);
    assign push       = bus.fire_valid && fireReady;
    assign pop        = spikeValid && bus.spike_ready;
    assign tsAccept   = timestep_end_i && !endPending_q && (state_q != CLEAR);

    assign wrPtr_d      = push ? wrPtr_q + (PTR_W+1)'(1) : wrPtr_q;
    assign rdPtr_d      = pop  ? rdPtr_q + (PTR_W+1)'(1) : rdPtr_q;
    assign endPending_d = endPending_q || tsAccept;
    assign drainedNext  = (wrPtr_d == rdPtr_d);

    assign bus.fire_ready     = fireReady;
    assign bus.spike_valid    = spikeValid;
    assign bus.source_address = empty ? '0 : mem_q[rdPtr_q[PTR_W-1:0]];
    assign step_clear_o       = stepClear_q;
    assign spike_count_o      = spikeCount_q;
    assign overflow_o         = overflow_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q[PTR_W-1:0]] <= bus.fire_address;
        end
    end

    // Pointers, step bookkeeping and the IDLE/SEND/CLEAR sequencer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            endPending_q <= 1'b0;
            stepClear_q  <= 1'b0;
            spikeCount_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            stepClear_q <= 1'b0;
            if (bus.fire_valid && full && !endPending_q) begin
                overflow_q <= 1'b1;
            end
            if (pop && (spikeCount_q != '1)) begin
                spikeCount_q <= spikeCount_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    endPending_q <= endPending_d;
                    if (push) begin
                        state_q <= SEND;
                    end else if (endPending_d) begin
                        state_q     <= CLEAR;
                        stepClear_q <= 1'b1;
                    end
                end
                SEND: begin
                    endPending_q <= endPending_d;
                    if (drainedNext) begin
                        if (endPending_d) begin
                            state_q     <= CLEAR;
                            stepClear_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                CLEAR: begin
                    state_q      <= IDLE;
                    endPending_q <= 1'b0;
                    spikeCount_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spike_source_dispatcher.sv
// Directed bench for spike_source_dispatcher: ordering, backpressure, overflow,
// step_clear timing and asynchronous reset, with hand-computed expectations.
module tb_spike_source_dispatcher;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              timestepEnd;
    logic              stepClear;
    logic [CNT_W-1:0]  spikeCount;
    logic              overflow;
    int                checks;
    int                errors;

    spike_source_dispatcher_if #(.ADDR_W(ADDR_W)) bus ();

    spike_source_dispatcher #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .timestep_end_i (timestepEnd),
        .step_clear_o   (stepClear),
        .spike_count_o  (spikeCount),
        .overflow_o     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen in the same window.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fv, input logic [ADDR_W-1:0] fa,
                                 input logic sr, input logic te);
        bus.fire_valid   = fv;
        bus.fire_address = fa;
        bus.spike_ready  = sr;
        timestepEnd      = te;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #12;
        rst = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_fire_ready",  32'(bus.fire_ready), 32'd1);
        checkOutput("rst_spike_valid", 32'(bus.spike_valid), 32'd0);
        checkOutput("rst_source",      32'(bus.source_address), 32'd0);
        checkOutput("rst_step_clear",  32'(stepClear), 32'd0);
        checkOutput("rst_count",       32'(spikeCount), 32'd0);
        checkOutput("rst_overflow",    32'(overflow), 32'd0);

        $display("[TB] test 1: back-to-back 3,4,5");
        applyStimulus(1'b1, 12'h003, 1'b1, 1'b0);
        tick();
        checkOutput("t1_src3", 32'(bus.source_address), 32'h003);
        checkOutput("t1_valid3", 32'(bus.spike_valid), 32'd1);
        applyStimulus(1'b1, 12'h004, 1'b1, 1'b0);
        tick();
        checkOutput("t1_src4", 32'(bus.source_address), 32'h004);
        applyStimulus(1'b1, 12'h005, 1'b1, 1'b0);
        tick();
        checkOutput("t1_src5", 32'(bus.source_address), 32'h005);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("t1_drained", 32'(bus.spike_valid), 32'd0);
        checkOutput("t1_count3", 32'(spikeCount), 32'd3);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t1_clear", 32'(stepClear), 32'd1);
        checkOutput("t1_count_in_clear", 32'(spikeCount), 32'd3);
        tick();
        checkOutput("t1_clear_done", 32'(stepClear), 32'd0);
        checkOutput("t1_count0", 32'(spikeCount), 32'd0);

        $display("[TB] test 2: fill, overflow, ordered drain");
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, ADDR_W'(i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("t2_full_ready", 32'(bus.fire_ready), 32'd0);
        checkOutput("t2_head", 32'(bus.source_address), 32'h001);
        checkOutput("t2_no_ovf_yet", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 12'h009, 1'b0, 1'b0);
        tick();
        checkOutput("t2_overflow", 32'(overflow), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput($sformatf("t2_order%0d", i), 32'(bus.source_address), 32'(i));
            tick();
        end
        checkOutput("t2_empty", 32'(bus.spike_valid), 32'd0);
        checkOutput("t2_count8", 32'(spikeCount), 32'd8);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t2_clear", 32'(stepClear), 32'd1);
        tick();

        $display("[TB] test 3: toggling spike_ready");
        applyStimulus(1'b1, 12'h007, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 12'h006, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t3_head7", 32'(bus.source_address), 32'h007);
        tick();
        checkOutput("t3_hold7", 32'(bus.source_address), 32'h007);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("t3_src6", 32'(bus.source_address), 32'h006);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("t3_hold6", 32'(bus.source_address), 32'h006);
        checkOutput("t3_valid6", 32'(bus.spike_valid), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("t3_drained", 32'(bus.spike_valid), 32'd0);
        checkOutput("t3_count2", 32'(spikeCount), 32'd2);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t3_clear", 32'(stepClear), 32'd1);
        tick();

        $display("[TB] test 4: empty step, repeated timestep_end");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("t4_clear", 32'(stepClear), 32'd1);
        checkOutput("t4_count0", 32'(spikeCount), 32'd0);
        checkOutput("t4_ready_in_clear", 32'(bus.fire_ready), 32'd0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t4_single_pulse", 32'(stepClear), 32'd0);
        tick();
        checkOutput("t4_still_low", 32'(stepClear), 32'd0);

        $display("[TB] test 5: timestep_end with final pop");
        applyStimulus(1'b1, 12'h00B, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("t5_src_b", 32'(bus.source_address), 32'h00B);
        tick();
        applyStimulus(1'b1, 12'h00A, 1'b0, 1'b0);
        checkOutput("t5_clear", 32'(stepClear), 32'd1);
        checkOutput("t5_ready_blocked", 32'(bus.fire_ready), 32'd0);
        tick();
        checkOutput("t5_ready_back", 32'(bus.fire_ready), 32'd1);
        checkOutput("t5_not_pushed", 32'(bus.spike_valid), 32'd0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t5_src_a", 32'(bus.source_address), 32'h00A);
        checkOutput("t5_new_count", 32'(spikeCount), 32'd0);
        tick();
        checkOutput("t5_count1", 32'(spikeCount), 32'd1);
        checkOutput("t5_drained", 32'(bus.spike_valid), 32'd0);

        $display("[TB] test 6: reset with spikes buffered");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, ADDR_W'(12'h020 + i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t6_buffered", 32'(bus.spike_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", 32'(bus.spike_valid), 32'd0);
        checkOutput("t6_async_src", 32'(bus.source_address), 32'd0);
        checkOutput("t6_async_ovf", 32'(overflow), 32'd0);
        checkOutput("t6_async_count", 32'(spikeCount), 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t6_no_clear%0d", i), 32'(stepClear), 32'd0);
            checkOutput($sformatf("t6_empty%0d", i), 32'(bus.spike_valid), 32'd0);
        end
        checkOutput("t6_ready", 32'(bus.fire_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
